// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle control unit and the datapath/memory side.
//   IR fields   : op_code[6:0], funct3[2:0], funct7_5 (IR[30])
//   Memory      : mem_ready (access completes this cycle), mem_read, mem_write
//   Datapath    : ir_write, pc_write, pc_src[1:0], reg_write, alu_src_b,
//                 alu_op[3:0], mem_to_reg[1:0], branch, b_type, auipc
//   Status      : trap, trap_cause[1:0], state[2:0], retired[CNT_W-1:0]
// slave  : the control unit (consumes IR fields / mem_ready, drives strobes)
// master : the datapath/memory side
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       op_code;
  logic [2:0]       funct3;
  logic             funct7_5;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             reg_write;
  logic             alu_src_b;
  logic [3:0]       alu_op;
  logic [1:0]       mem_to_reg;
  logic             mem_read;
  logic             mem_write;
  logic             branch;
  logic             b_type;
  logic             auipc;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport slave (
    input  op_code, funct3, funct7_5, mem_ready,
    output ir_write, pc_write, pc_src, reg_write, alu_src_b, alu_op,
           mem_to_reg, mem_read, mem_write, branch, b_type, auipc,
           trap, trap_cause, state, retired
  );

  modport master (
    output op_code, funct3, funct7_5, mem_ready,
    input  ir_write, pc_write, pc_src, reg_write, alu_src_b, alu_op,
           mem_to_reg, mem_read, mem_write, branch, b_type, auipc,
           trap, trap_cause, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB against a
// shared memory with a ready handshake and bounded wait, traps (sticky) on
// illegal opcodes or memory timeout, and counts retired instructions.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset; forces all control strobes low
//   bus  - multicycle_control_if.slave (IR fields, mem handshake, strobes,
//          trap status, debug state, retired counter)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_W        = 5,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_control_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0]      ALU_ADD = 4'b0000;
  localparam logic [3:0]      ALU_XOR = 4'b0100;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;

  logic is_load, is_store, is_opimm, is_op, is_branch;
  logic is_jal, is_jalr, is_lui, is_auipc, legal;
  logic timeout_hit;

  logic       ir_write, pc_write, reg_write, alu_src_b;
  logic       mem_read, mem_write, branch, b_type, auipc;
  logic [1:0] pc_src, mem_to_reg;
  logic [3:0] alu_op;

  // Only word loads/stores, beq/bne and jalr with funct3=000 are accepted.
  always_comb begin
    is_load   = (bus.op_code == OPC_LOAD)   && (bus.funct3 == 3'b010);
    is_store  = (bus.op_code == OPC_STORE)  && (bus.funct3 == 3'b010);
    is_opimm  = (bus.op_code == OPC_OPIMM);
    is_op     = (bus.op_code == OPC_OP);
    is_branch = (bus.op_code == OPC_BRANCH) && (bus.funct3[2:1] == 2'b00);
    is_jal    = (bus.op_code == OPC_JAL);
    is_jalr   = (bus.op_code == OPC_JALR)   && (bus.funct3 == 3'b000);
    is_lui    = (bus.op_code == OPC_LUI);
    is_auipc  = (bus.op_code == OPC_AUIPC);
    legal     = is_load | is_store | is_opimm | is_op | is_branch |
                is_jal | is_jalr | is_lui | is_auipc;
  end

  // Wait counter holds (cycles waited - 1) on the last allowed cycle.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, pc_write};
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    trap_d     = trap_q;
    cause_d    = cause_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    reg_write  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    b_type     = 1'b0;
    auipc      = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DECODE: begin
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end

      S_EXEC: begin
        alu_src_b = ~(is_op | is_branch | is_jal);
        auipc     = is_auipc;
        if (is_op)
          alu_op = {bus.funct7_5, bus.funct3};
        else if (is_opimm)
          // IR[30] only selects SRAI vs SRLI; elsewhere it is immediate bits.
          alu_op = {bus.funct7_5 & (bus.funct3 == 3'b101), bus.funct3};
        else if (is_branch)
          alu_op = ALU_XOR;

        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          branch   = 1'b1;
          b_type   = ~bus.funct3[0];
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end else if (is_jal || is_jalr) begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b10;
          pc_src     = is_jal ? 2'b10 : 2'b01;
          pc_write   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (bus.mem_ready) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b11;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load ? 2'b11 : (is_lui ? 2'b01 : 2'b00);
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are gated by rst so an asynchronous reset kills them immediately.
  assign bus.ir_write   = ir_write  & ~rst;
  assign bus.pc_write   = pc_write  & ~rst;
  assign bus.reg_write  = reg_write & ~rst;
  assign bus.alu_src_b  = alu_src_b & ~rst;
  assign bus.mem_read   = mem_read  & ~rst;
  assign bus.mem_write  = mem_write & ~rst;
  assign bus.branch     = branch    & ~rst;
  assign bus.b_type     = b_type    & ~rst;
  assign bus.auipc      = auipc     & ~rst;
  assign bus.pc_src     = rst ? '0 : pc_src;
  assign bus.alu_op     = rst ? '0 : alu_op;
  assign bus.mem_to_reg = rst ? '0 : mem_to_reg;
  assign bus.trap       = trap_q;
  assign bus.trap_cause = cause_q;
  assign bus.state      = state_q;
  assign bus.retired    = retired_q;

endmodule
